// File: rtl/tag_mem_bank.sv
// Array-side responder for the tag memory port: three word-addressed banks driven by the
// PC_B / WE / SE phase sequence, with registered read data and protocol error flags.
module tag_mem_bank #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned DEPTH          = 64,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_B,
  input  logic              WE,
  input  logic              SE,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [2:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] mem_read_in,
  output logic              mem_ready,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              proto_err,
  output logic [2:0]        err_code
);

  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] ErrSel      = 3'd1;
  localparam logic [2:0] ErrNoPre    = 3'd2;
  localparam logic [2:0] ErrConflict = 3'd3;
  localparam logic [2:0] ErrRange    = 3'd4;

  typedef enum logic [1:0] {StClear, StIdle, StArmed, StDone} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_bank;
  logic                r_addr_ok;
  logic [DATA_W-1:0]   r_read;
  logic                r_ready;
  logic                r_wr_ack;
  logic                r_rd_ack;
  logic                r_proto_err;
  logic [2:0]          r_err_code;
  logic [DATA_W-1:0]   r_mem [3][DEPTH];

  logic                w_sel_onehot;
  logic [1:0]          w_sel_bank;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_prefetch;
  logic                w_latch;
  logic                w_write;
  logic                w_echo;
  logic                w_wr_ack_d;
  logic                w_rd_ack_d;
  logic                w_err;
  logic [2:0]          w_err_code_d;

  always_comb begin
    w_sel_onehot = 1'b1;
    w_sel_bank   = 2'd0;
    unique case (mem_sel)
      3'b001:  w_sel_bank = 2'd0;
      3'b010:  w_sel_bank = 2'd1;
      3'b100:  w_sel_bank = 2'd2;
      default: w_sel_onehot = 1'b0;
    endcase
  end

  assign w_in_range = ({1'b0, mem_address} < DepthW);
  assign w_prefetch = w_in_range ? r_mem[w_sel_bank][mem_address] : '0;

  always_comb begin
    w_state_d    = r_state;
    w_latch      = 1'b0;
    w_write      = 1'b0;
    w_echo       = 1'b0;
    w_wr_ack_d   = 1'b0;
    w_rd_ack_d   = 1'b0;
    w_err        = 1'b0;
    w_err_code_d = r_err_code;
    if (r_state == StClear) begin
      if (r_clr_addr == LastAddr) w_state_d = StIdle;
    end else if (!PC_B) begin
      // A bad select drops any armed access, so the next WE/SE is treated as unprecharged.
      if (w_sel_onehot) begin
        w_latch   = 1'b1;
        w_state_d = StArmed;
        if (!w_in_range) begin
          w_err        = 1'b1;
          w_err_code_d = ErrRange;
        end
      end else begin
        w_state_d    = StIdle;
        w_err        = 1'b1;
        w_err_code_d = ErrSel;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (WE || SE) begin
            w_err        = 1'b1;
            w_err_code_d = ErrNoPre;
          end
        end
        StArmed: begin
          if (WE && SE) begin
            w_err        = 1'b1;
            w_err_code_d = ErrConflict;
            w_state_d    = StIdle;
          end else if (WE) begin
            w_write    = r_addr_ok;
            w_echo     = 1'b1;
            w_wr_ack_d = 1'b1;
            w_state_d  = StDone;
          end else if (SE) begin
            w_rd_ack_d = 1'b1;
            w_state_d  = StDone;
          end
        end
        StDone: begin
          if (!WE && !SE) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CLEAR_ON_RESET ? StClear : StIdle;
      r_clr_addr  <= '0;
      r_addr      <= '0;
      r_bank      <= 2'd0;
      r_addr_ok   <= 1'b0;
      r_read      <= '0;
      r_ready     <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      r_state     <= w_state_d;
      r_ready     <= (r_state != StClear);
      r_wr_ack    <= w_wr_ack_d;
      r_rd_ack    <= w_rd_ack_d;
      r_proto_err <= w_err;
      r_err_code  <= w_err_code_d;
      if (r_state == StClear) r_clr_addr <= r_clr_addr + 1'b1;
      if (w_latch) begin
        r_addr    <= mem_address;
        r_bank    <= w_sel_bank;
        r_addr_ok <= w_in_range;
        r_read    <= w_prefetch;
      end else if (w_echo) begin
        r_read    <= mem_data_out;
      end
    end
  end

  // Contents are never reset; a write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == StClear) begin
        r_mem[0][r_clr_addr] <= '0;
        r_mem[1][r_clr_addr] <= '0;
        r_mem[2][r_clr_addr] <= '0;
      end else if (w_write) begin
        r_mem[r_bank][r_addr] <= mem_data_out;
      end
    end
  end

  assign mem_read_in = r_read;
  assign mem_ready   = r_ready;
  assign wr_ack      = r_wr_ack;
  assign rd_ack      = r_rd_ack;
  assign proto_err   = r_proto_err;
  assign err_code    = r_err_code;

endmodule
